// File: rtl/conv_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pack_pkg
//  Description : Shared types and default widths for the convolution result
//                packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pack_pkg;

    localparam int DATA_W_IN  = 16;
    localparam int ADDR_IN_W  = 6;
    localparam int ADDR_OUT_W = 5;
    localparam int PACK_RATIO = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } pack_state_e;

endpackage : conv_pack_pkg
`default_nettype wire

// File: rtl/conv_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_packer
//  Description : Packs 16-bit convolution results two per 32-bit output word,
//                flushes a trailing odd sample and signals completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_result_packer #(
    parameter int DATA_W_IN  = conv_pack_pkg::DATA_W_IN,
    parameter int ADDR_IN_W  = conv_pack_pkg::ADDR_IN_W,
    parameter int ADDR_OUT_W = conv_pack_pkg::ADDR_OUT_W
) (
    input  logic                                        clk,
    input  logic                                        rst_a,
    input  logic                                        in_start,
    input  logic                                        in_valid,
    input  logic [ADDR_IN_W-1:0]                        in_addr,
    input  logic [DATA_W_IN-1:0]                        in_data,
    input  logic                                        in_done,
    output logic                                        out_wr_en,
    output logic [ADDR_OUT_W-1:0]                       out_addr,
    output logic [conv_pack_pkg::PACK_RATIO*DATA_W_IN-1:0] out_data,
    output logic                                        busy,
    output logic                                        done,
    output logic [ADDR_IN_W:0]                          count,
    output logic                                        overflow,
    output logic                                        seq_err
);
    import conv_pack_pkg::*;

    localparam int OUT_W = PACK_RATIO * DATA_W_IN;

    pack_state_e             state_q,    state_d;
    logic [ADDR_IN_W:0]      count_q,    count_d;
    logic [DATA_W_IN-1:0]    low_q,      low_d;
    logic                    overflow_q, overflow_d;
    logic                    seq_err_q,  seq_err_d;
    logic                    wr_en_q,    wr_en_d;
    logic [ADDR_OUT_W-1:0]   addr_q,     addr_d;
    logic [OUT_W-1:0]        data_q,     data_d;
    logic                    done_q,     done_d;

    // Count saturates at exactly 2**ADDR_IN_W, so its MSB alone marks "full".
    logic full;
    assign full = count_q[ADDR_IN_W];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        low_d      = low_q;
        overflow_d = overflow_q;
        seq_err_d  = seq_err_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;

        if (in_start) begin
            state_d    = COLLECT;
            count_d    = '0;
            low_d      = '0;
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                COLLECT: begin
                    if (in_valid) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            if (in_addr != count_q[ADDR_IN_W-1:0])
                                seq_err_d = 1'b1;
                            if (!count_q[0]) begin
                                low_d = in_data;
                            end else begin
                                wr_en_d = 1'b1;
                                addr_d  = count_q[ADDR_IN_W-1:1];
                                data_d  = {in_data, low_q};
                            end
                            count_d = count_q + {{ADDR_IN_W{1'b0}}, 1'b1};
                        end
                    end
                    if (in_done) begin
                        if (count_d[0]) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = DONE;
                            // With no closing write, pulse done straight away;
                            // otherwise DONE raises it after the write cycle.
                            done_d  = !wr_en_d;
                        end
                    end
                end
                FLUSH: begin
                    wr_en_d = 1'b1;
                    addr_d  = count_q[ADDR_IN_W-1:1];
                    data_d  = {{DATA_W_IN{1'b0}}, low_q};
                    state_d = DONE;
                end
                DONE: begin
                    done_d  = !done_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q    <= IDLE;
            count_q    <= '0;
            low_q      <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            low_q      <= low_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    assign out_wr_en = wr_en_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign seq_err   = seq_err_q;

endmodule : conv_result_packer
`default_nettype wire

// File: tb/tb_conv_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_result_packer
//  Description : Directed self-checking bench for conv_result_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_packer;

    logic        clk;
    logic        rst_a;
    logic        in_start;
    logic        in_valid;
    logic [5:0]  in_addr;
    logic [15:0] in_data;
    logic        in_done;
    logic        out_wr_en;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [6:0]  count;
    logic        overflow;
    logic        seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    conv_result_packer dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_done   (in_done),
        .out_wr_en (out_wr_en),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then stable from the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [5:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wr_en"}, out_wr_en, 1'b1);
        chk({tag, "_addr"},  out_addr,  a);
        chk({tag, "_data"},  out_data,  d);
    endtask

    initial begin
        rst_a = 1'b1; in_start = 1'b0; in_valid = 1'b0;
        in_addr = '0; in_data = '0; in_done = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_addr",  out_addr,  0);
        chk("rst_data",  out_data,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_count", count,     0);
        chk("rst_ovf",   overflow,  0);
        chk("rst_seq",   seq_err,   0);
        rst_a = 1'b0;
        tick();

        // Five samples: two packed words then a padded flush
        start();
        chk("t1_busy", busy, 1);
        send(16'h0001, 6'd0); chk("t1_s0_nowr", out_wr_en, 0);
        send(16'h0002, 6'd1); chk_wr("t1_w0", 5'd0, 32'h0002_0001);
        send(16'h0003, 6'd2); chk("t1_s2_nowr", out_wr_en, 0);
        send(16'h0004, 6'd3); chk_wr("t1_w1", 5'd1, 32'h0004_0003);
        send(16'h0005, 6'd4); chk("t1_s4_nowr", out_wr_en, 0);
        chk("t1_count", count, 5);
        in_done = 1'b1; tick(); in_done = 1'b0;
        chk("t1_flush_pending", out_wr_en, 0);
        chk("t1_done_early0", done, 0);
        tick();
        chk_wr("t1_w2", 5'd2, 32'h0000_0005);
        chk("t1_done_early1", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_done_nowr", out_wr_en, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_count_hold", count, 5);
        chk("t1_seq", seq_err, 0);

        // Four samples, in_done together with the last one
        start();
        send(16'h0001, 6'd0);
        send(16'h0002, 6'd1); chk_wr("t2_w0", 5'd0, 32'h0002_0001);
        send(16'h0003, 6'd2);
        in_done = 1'b1; send(16'h0004, 6'd3); in_done = 1'b0;
        chk_wr("t2_w1", 5'd1, 32'h0004_0003);
        chk("t2_done_early", done, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_no_flush", out_wr_en, 0);
        tick();
        chk("t2_done_pulse", done, 0);
        chk("t2_count", count, 4);

        // Empty run
        start();
        in_done = 1'b1; tick(); in_done = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_nowr", out_wr_en, 0);
        tick();
        chk("t3_done_pulse", done, 0);
        chk("t3_nowr2", out_wr_en, 0);
        chk("t3_count", count, 0);

        // Overflow: 64 accepted, the 65th dropped
        start();
        for (int i = 0; i < 64; i++) begin
            send(16'(i + 16'h100), 6'(i));
            if (i % 2 == 1)
                chk_wr($sformatf("t4_w%0d", i / 2), 5'(i / 2),
                       {16'(i + 16'h100), 16'(i - 1 + 16'h100)});
        end
        chk("t4_count64", count, 64);
        chk("t4_no_ovf_yet", overflow, 0);
        send(16'hDEAD, 6'd0);
        chk("t4_drop_nowr", out_wr_en, 0);
        chk("t4_ovf", overflow, 1);
        chk("t4_count_sat", count, 64);
        chk("t4_seq", seq_err, 0);
        in_done = 1'b1; tick(); in_done = 1'b0;
        chk("t4_done", done, 1);
        tick();

        // Address skip: 0, 1, 3
        start();
        send(16'h000A, 6'd0);
        send(16'h000B, 6'd1); chk_wr("t5_w0", 5'd0, 32'h000B_000A);
        chk("t5_seq_clean", seq_err, 0);
        send(16'h000C, 6'd3);
        chk("t5_seq", seq_err, 1);
        in_done = 1'b1; tick(); in_done = 1'b0;
        tick();
        chk_wr("t5_flush", 5'd1, 32'h0000_000C);
        tick();
        chk("t5_done", done, 1);
        tick();

        // Restart mid-run, then asynchronous reset mid-collect
        start();
        send(16'h0001, 6'd0);
        send(16'h0002, 6'd1);
        send(16'h0003, 6'd5);
        chk("t6_seq_set", seq_err, 1);
        in_start = 1'b1; in_valid = 1'b1; in_data = 16'h0099; in_addr = 6'd3;
        tick();
        in_start = 1'b0; in_valid = 1'b0;
        chk("t6_count_clr", count, 0);
        chk("t6_seq_clr", seq_err, 0);
        chk("t6_ignored_nowr", out_wr_en, 0);
        send(16'h0011, 6'd0);
        send(16'h0022, 6'd1); chk_wr("t6_w0", 5'd0, 32'h0022_0011);
        #2 rst_a = 1'b1;
        #1;
        chk("t6_rst_wr_en", out_wr_en, 0);
        chk("t6_rst_data",  out_data,  0);
        chk("t6_rst_count", count,     0);
        chk("t6_rst_busy",  busy,      0);
        #2 rst_a = 1'b0;
        tick();
        chk("t6_post_rst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_conv_result_packer
`default_nettype wire

// File: doc/conv_result_packer.md
Name: conv_result_packer

Overview:
- Sits directly downstream of the convolution core, between its result port (dataZ/memZ_addr/writeZ/done) and the 32-bit AIP output memory (wrDataMemOut_0/wrAddrMemOut_0/wrEnMemOut_0).
- Packs consecutive 16-bit convolution results two per 32-bit word, so the host reads half as many words.
- Flushes a trailing odd sample as a zero-padded word when the core finishes, then raises its own done pulse.
- Tracks the sample count and flags overflow and out-of-sequence addresses.

Parameters:
- DATA_W_IN, 16, width of one convolution result sample.
- ADDR_IN_W, 6, width of the core's result address; the block accepts at most 2**ADDR_IN_W samples.
- ADDR_OUT_W, 5, width of the packed-word address; must equal ADDR_IN_W-1.

Ports:
- clk  in  1  clock.
- rst_a  in  1  asynchronous, active-high reset.
- in_start  in  1  start pulse, same pulse that starts the core; restarts packing.
- in_valid  in  1  core result write strobe (writeZ).
- in_addr  in  ADDR_IN_W  core result address (memZ_addr).
- in_data  in  DATA_W_IN  core result sample (dataZ).
- in_done  in  1  core completion pulse.
- out_wr_en  out  1  output-memory write enable.
- out_addr  out  ADDR_OUT_W  packed-word address.
- out_data  out  2*DATA_W_IN  packed word: {odd sample, even sample}.
- busy  out  1  packing in progress.
- done  out  1  one-cycle completion pulse (drives intIPCore_Done).
- count  out  ADDR_IN_W+1  samples accepted since the last start.
- overflow  out  1  sticky: a sample arrived after 2**ADDR_IN_W were accepted.
- seq_err  out  1  sticky: in_addr differed from the expected sample index.

Behaviour:
- Reset: all outputs, registers and counters are 0; state is IDLE. Reset takes effect immediately, including mid-operation.
- Registered outputs: out_wr_en, out_addr, out_data and done are registered.
- Latency: a write triggered at clock edge k is visible (out_wr_en=1) for exactly the cycle after edge k.
- States:
  - IDLE: busy=0. in_start moves to COLLECT.
  - COLLECT: busy=1. Accepts samples.
  - FLUSH: busy=1. Writes the padded trailing word.
  - DONE: busy=1. Asserts done for one cycle, then moves to IDLE.
- in_start in any state:
  - Next state is COLLECT.
  - Clears count, overflow, seq_err, the low-half holding register and the expected index.
  - Aborts any pending flush.
  - Any in_valid in the same cycle is ignored.
- Sample acceptance in COLLECT (in_valid=1, count < 2**ADDR_IN_W):
  - If in_addr != count[ADDR_IN_W-1:0], set seq_err. The sample is still packed by the internal count; in_addr is not used for placement.
  - count even: store in_data in the low-half register. No write.
  - count odd: write out_data={in_data, low_half}, out_addr=count[ADDR_IN_W-1:1].
  - count increments by 1.
- Overflow: in_valid with count == 2**ADDR_IN_W drops the sample and sets overflow; count saturates.
- in_done in COLLECT:
  - A simultaneous in_valid is processed first, using the updated count.
  - Final count odd: go to FLUSH. The next edge writes {0, low_half} at count>>1 and the state moves to DONE.
  - Otherwise: go to DONE directly.
- done timing: done is high exactly one cycle, in the cycle after the final out_wr_en cycle. If no final write occurs, done is high in the cycle after the in_done edge.
- Ignored inputs: in_valid outside COLLECT, and in_done outside COLLECT.
- Hold behaviour: count, overflow and seq_err hold their values in IDLE until the next in_start.

Decomposition:
- Shared package conv_pack_pkg holds:
  - the state enum (IDLE, COLLECT, FLUSH, DONE);
  - PACK_RATIO=2;
  - default widths DATA_W_IN=16, ADDR_IN_W=6, ADDR_OUT_W=5.
- No sub-module. The FSM, the holding register and the counters are implemented in one module.

Test Plan:
- Five samples: start, samples 0x0001..0x0005 at addresses 0..4, then in_done.
  - Required writes: addr0=0x00020001, addr1=0x00040003, addr2=0x00000005 (flush).
  - done one cycle after the last write; count=5; seq_err=0.
- Last sample with done: four samples, with in_valid and in_done in the same cycle on the 4th sample.
  - Required: writes addr0=0x00020001, addr1=0x00040003; no FLUSH.
  - done in the cycle after the addr1 write.
- Empty run: start, then in_done with no samples.
  - Required: no out_wr_en; done high in the cycle after in_done; count=0.
- Overflow: 65 samples with default parameters.
  - Required: 32 writes (addr 0..31); sample 65 dropped; overflow=1; count=64.
- Address skip: samples at addresses 0, 1, 3 with data 0xA, 0xB, 0xC.
  - Required: seq_err=1; addr0=0x000B000A; the flush after done writes addr1=0x0000000C.
- Restart and reset mid-run:
  - in_start after 3 samples: count returns to 0, flags clear, and the next pair writes addr0.
  - rst_a asserted mid-COLLECT: all outputs go to 0 immediately.
